lbist_engine: RTL and testbench
===============================

# lbist_engine

Logic-BIST driver for the small combinational benchmark cores (c4-class: 4 primary inputs, 1 primary output). It generates pseudo-random test patterns from an LFSR, drives them onto the core's primary inputs, compacts the core's primary-output responses into a MISR signature, and compares the final signature against a golden value. It sits outside the core under test (CUT) and forms the stimulus/response end of the CUT's PI/PO interface.

## Interface
- PI_W, 4: pattern width, equal to the CUT primary-input count.
- PO_W, 1: CUT primary-output count; must be ≤ SIG_W.
- SIG_W, 16: MISR width.
- POLY, 16'h1021: MISR feedback polynomial (x^16+x^12+x^5+1).
- TAPS, 4'b1100: LFSR feedback tap mask; the default is maximal length for PI_W=4.
- SEED, 4'b0001: LFSR seed; must be nonzero.
- NPAT, 15: patterns per run, from 1 to 2^PI_W−1.
- GOLDEN, 16'h0000: expected signature.
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  run request, sampled only in IDLE or DONE.
- cut_pi  out  PI_W  pattern driven to the CUT primary inputs.
- cut_po  in  PO_W  CUT primary-output response.
- busy  out  1  high in RUN and CMP.
- done  out  1  high in DONE.
- pass  out  1  result of the last completed run; valid while done=1.
- signature  out  SIG_W  current MISR contents.
- pat_idx  out  $clog2(NPAT+1)  index of the pattern currently applied.

## Operation
- The FSM has four states: IDLE, RUN, CMP, DONE.
- IDLE → RUN when start=1. On this transition: LFSR←SEED, MISR←0, pat_idx←0, pass←0.
- While in RUN:
  - cut_pi = LFSR state.
  - At each clock edge, the MISR absorbs cut_po, the LFSR advances, and pat_idx increments.
  - RUN → CMP at the edge that absorbs pattern NPAT−1.
- CMP → DONE unconditionally; at this edge pass←(signature==GOLDEN).
- DONE holds until start=1, then re-enters RUN with the same initialisation as IDLE → RUN.
- start during RUN or CMP is ignored. There is no abort except reset.
- cut_pi = 0 in every state other than RUN.
- LFSR update (Fibonacci): q←{q[PI_W−2:0], ^(q & TAPS)}. With the defaults the sequence is 0001, 0010, 0100, 1001, 0011, 0110, 1101, 1010, 0101, 1011, 0111, 1111, 1110, 1100, 1000.
- MISR update: sig←(sig<<1) ^ ({SIG_W{sig[SIG_W−1]}} & POLY) ^ zero-extend(cut_po). Arithmetic is modulo 2^SIG_W and shifted-out bits are discarded.
- Reset mid-run is asynchronous: state←IDLE, and all outputs take their reset values immediately.

## Timing
- Reset values: cut_pi=0, busy=0, done=0, pass=0, signature=0, pat_idx=0.
- start sampled high at edge t0:
  - Cycles t0+1 … t0+NPAT are RUN; pattern k is driven during cycle t0+1+k.
  - CMP occupies cycle t0+NPAT+1.
  - done=1 from edge t0+NPAT+2.
- The CUT path is single-cycle combinational: cut_po must be valid within the same cycle as the cut_pi that produced it.
- All outputs are registered except cut_pi, which is a registered LFSR value gated by a registered state decode (no combinational input-to-output path).

## Structure
- The package lbist_pkg holds:
  - the state enum (IDLE, RUN, CMP, DONE);
  - the default POLY, TAPS and SEED constants;
  - a misr_next() function shared with the reference model.
- Sub-module lbist_lfsr (parameters PI_W, TAPS, SEED; ports clk, rst_n, load, en, q) is instantiated once.
- The MISR and FSM are implemented inline in lbist_engine.

## Test plan
- Reset, then idle for 5 cycles → all outputs 0; cut_pi=0.
- cut_po tied 0, GOLDEN=0, start pulse at t0:
  - cut_pi steps through 0001 … 1000 during cycles t0+1 … t0+15;
  - done rises at t0+17; signature=16'h0000; pass=1.
- cut_po=1 only while the last pattern (1000) is applied → signature=16'h0001, pass=0.
- cut_po=1 only during the second-to-last pattern (1100) → signature=16'h0002.
- Core behaviour NAND-of-NANDs (c4 equivalent):
  - cut_po is computed from cut_pi by the bench model;
  - the final signature must equal the model MISR;
  - a second start issued in DONE reproduces an identical signature.
- Edge cases:
  - assert rst_n=0 at pattern 7 → immediate all-zero outputs; a new start gives a full 15-pattern run;
  - start pulses held during RUN → no restart, run length unchanged.

Source files
------------

// File: rtl/lbist_pkg.sv
// rtl/lbist_pkg.sv - shared state encoding, default constants and MISR step for the logic-BIST engine
package lbist_pkg;

    typedef enum logic [1:0] {IDLE, RUN, CMP, DONE} state_t;

    localparam int          MISR_W   = 16;
    localparam logic [15:0] DEF_POLY = 16'h1021;
    localparam logic [3:0]  DEF_TAPS = 4'b1100;
    localparam logic [3:0]  DEF_SEED = 4'b0001;

    // One MISR clock: shift left, fold the shifted-out bit through the polynomial, inject the response.
    function automatic logic [MISR_W-1:0] misr_next(input logic [MISR_W-1:0] sig,
                                                    input logic [MISR_W-1:0] poly,
                                                    input logic [MISR_W-1:0] din);
        return {sig[MISR_W-2:0], 1'b0} ^ ({MISR_W{sig[MISR_W-1]}} & poly) ^ din;
    endfunction

endpackage

// File: rtl/lbist_engine_if.sv
// rtl/lbist_engine_if.sv - control/status and CUT pattern/response bundle of the logic-BIST engine
interface lbist_engine_if #(
    parameter int PI_W  = 4,
    parameter int PO_W  = 1,
    parameter int SIG_W = 16,
    parameter int IDX_W = 4
);
    logic             start;
    logic [PI_W-1:0]  cut_pi;
    logic [PO_W-1:0]  cut_po;
    logic             busy;
    logic             done;
    logic             pass;
    logic [SIG_W-1:0] signature;
    logic [IDX_W-1:0] pat_idx;

    modport slave  (input  start, cut_po,
                    output cut_pi, busy, done, pass, signature, pat_idx);
    modport master (output start, cut_po,
                    input  cut_pi, busy, done, pass, signature, pat_idx);
endinterface

// File: rtl/lbist_lfsr.sv
// rtl/lbist_lfsr.sv - Fibonacci pattern LFSR with synchronous seed load
module lbist_lfsr #(
    parameter int              PI_W = 4,
    parameter logic [PI_W-1:0] TAPS = 4'b1100,
    parameter logic [PI_W-1:0] SEED = 4'b0001
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic            en,
    output logic [PI_W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= SEED;
        end else if (load) begin
            q <= SEED;
        end else if (en) begin
            q <= {q[PI_W-2:0], ^(q & TAPS)};
        end
    end

endmodule

// File: rtl/lbist_engine.sv
// rtl/lbist_engine.sv - LFSR pattern generation, MISR compaction and golden-signature compare
module lbist_engine
    import lbist_pkg::*;
#(
    parameter int               PI_W   = 4,
    parameter int               PO_W   = 1,
    parameter int               SIG_W  = MISR_W,
    parameter logic [SIG_W-1:0] POLY   = DEF_POLY,
    parameter logic [PI_W-1:0]  TAPS   = DEF_TAPS,
    parameter logic [PI_W-1:0]  SEED   = DEF_SEED,
    parameter int               NPAT   = 15,
    parameter logic [SIG_W-1:0] GOLDEN = '0
) (
    input  logic           clk,
    input  logic           rst_n,
    lbist_engine_if.slave  bus
);

    localparam int             IDX_W = $clog2(NPAT + 1);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NPAT - 1);

    state_t           state;
    logic             run_q;
    logic             busy_q;
    logic             done_q;
    logic             pass_q;
    logic [SIG_W-1:0] misr_q;
    logic [SIG_W-1:0] po_ext;
    logic [IDX_W-1:0] idx_q;
    logic [PI_W-1:0]  lfsr_q;
    logic             lfsr_load;
    logic             lfsr_en;

    assign lfsr_load = bus.start && (state == IDLE || state == DONE);
    assign lfsr_en   = (state == RUN);

    lbist_lfsr #(.PI_W(PI_W), .TAPS(TAPS), .SEED(SEED)) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (lfsr_load),
        .en    (lfsr_en),
        .q     (lfsr_q)
    );

    always_comb begin
        po_ext             = '0;
        po_ext[PO_W-1:0]   = bus.cut_po;
    end

    // run_q is a dedicated flop so cut_pi gating never decodes the state vector combinationally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            run_q  <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            pass_q <= 1'b0;
            misr_q <= '0;
            idx_q  <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        state  <= RUN;
                        run_q  <= 1'b1;
                        busy_q <= 1'b1;
                        done_q <= 1'b0;
                        pass_q <= 1'b0;
                        misr_q <= '0;
                        idx_q  <= '0;
                    end
                end
                RUN: begin
                    misr_q <= misr_next(misr_q, POLY, po_ext);
                    idx_q  <= idx_q + 1'b1;
                    if (idx_q == LAST) begin
                        state <= CMP;
                        run_q <= 1'b0;
                    end
                end
                CMP: begin
                    state  <= DONE;
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                    pass_q <= (misr_q == GOLDEN);
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.cut_pi    = lfsr_q & {PI_W{run_q}};
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.pass      = pass_q;
    assign bus.signature = misr_q;
    assign bus.pat_idx   = idx_q;

endmodule

// File: tb/tb_lbist_engine.sv
// tb/tb_lbist_engine.sv - self-checking bench for lbist_engine with a lookup-table CUT model
module tb_lbist_engine;

    logic clk;
    logic rst_n;
    int   vec_n  = 0;
    int   miss_n = 0;

    logic [15:0] cur_lut;
    logic [3:0]  pats [15];

    lbist_engine_if #(.PI_W(4), .PO_W(1), .SIG_W(16), .IDX_W(4)) bus ();

    lbist_engine dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The CUT is any 4-input single-output function, held as a 16-entry truth table.
    always_comb bus.cut_po = cur_lut[bus.cut_pi];

    typedef struct {
        logic [15:0] lut;
        logic [15:0] exp_sig;
        logic        exp_pass;
    } vec_t;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vec_n++;
        if (act !== exp) begin
            miss_n++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic check_zero(input string nm);
        check({nm, " cut_pi"}, 32'(bus.cut_pi), 0);
        check({nm, " busy"}, 32'(bus.busy), 0);
        check({nm, " done"}, 32'(bus.done), 0);
        check({nm, " pass"}, 32'(bus.pass), 0);
        check({nm, " signature"}, 32'(bus.signature), 0);
        check({nm, " pat_idx"}, 32'(bus.pat_idx), 0);
    endtask

    function automatic logic [15:0] model_sig(input logic [15:0] lut);
        int sig = 0;
        for (int k = 0; k < 15; k++) begin
            int fb = (sig >= 32768) ? 'h1021 : 0;
            sig = ((sig * 2) % 65536) ^ fb ^ int'(lut[pats[k]]);
        end
        return 16'(sig);
    endfunction

    function automatic logic [15:0] nand_lut();
        logic [15:0] l;
        for (int v = 0; v < 16; v++) begin
            logic [3:0] b = 4'(v);
            l[v] = !(!(b[0] & b[1]) & !(b[2] & b[3]));
        end
        return l;
    endfunction

    // Full run from IDLE/DONE; checks pattern order, run length and done timing.
    task automatic run_vec(input logic hold, input string nm,
                           output logic [15:0] sig, output logic p);
        @(negedge clk) bus.start = 1'b1;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (k == 0 && !hold) bus.start = 1'b0;
            check($sformatf("%s cut_pi[%0d]", nm, k), 32'(bus.cut_pi), 32'(pats[k]));
            check($sformatf("%s pat_idx[%0d]", nm, k), 32'(bus.pat_idx), k);
            if (k == 0 || k == 14) begin
                check({nm, " busy run"}, 32'(bus.busy), 1);
                check({nm, " pass cleared"}, 32'(bus.pass), 0);
            end
        end
        @(negedge clk);
        bus.start = 1'b0;
        check({nm, " cmp busy"}, 32'(bus.busy), 1);
        check({nm, " cmp done"}, 32'(bus.done), 0);
        check({nm, " cmp cut_pi"}, 32'(bus.cut_pi), 0);
        @(negedge clk);
        check({nm, " done"}, 32'(bus.done), 1);
        check({nm, " busy idle"}, 32'(bus.busy), 0);
        sig = bus.signature;
        p   = bus.pass;
    endtask

    vec_t        tbl [6];
    logic [15:0] sig, sig2, exp;
    logic        p;

    initial begin
        pats = '{4'h1, 4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA,
                 4'h5, 4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8};
        tbl[0] = '{16'h0000, 16'h0000, 1'b1};
        tbl[1] = '{16'h0100, 16'h0001, 1'b0};
        tbl[2] = '{16'h1000, 16'h0002, 1'b0};
        tbl[3] = '{16'h0002, 16'h4000, 1'b0};
        tbl[4] = '{16'h0004, 16'h2000, 1'b0};
        tbl[5] = '{16'h0102, 16'h4001, 1'b0};

        cur_lut   = '0;
        bus.start = 1'b0;
        rst_n     = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check_zero("idle");
        end

        foreach (tbl[i]) begin
            cur_lut = tbl[i].lut;
            run_vec(1'b0, $sformatf("tbl%0d", i), sig, p);
            check($sformatf("tbl%0d signature", i), 32'(sig), 32'(tbl[i].exp_sig));
            check($sformatf("tbl%0d pass", i), 32'(p), 32'(tbl[i].exp_pass));
        end

        cur_lut = nand_lut();
        exp     = model_sig(cur_lut);
        run_vec(1'b0, "nand", sig, p);
        check("nand signature", 32'(sig), 32'(exp));
        check("nand pass", 32'(p), 32'(exp == 16'h0));
        run_vec(1'b0, "nand rerun", sig2, p);
        check("nand rerun signature", 32'(sig2), 32'(exp));

        for (int r = 0; r < 4; r++) begin
            cur_lut = 16'($urandom);
            exp     = model_sig(cur_lut);
            run_vec(1'b0, $sformatf("rand%0d", r), sig, p);
            check($sformatf("rand%0d signature", r), 32'(sig), 32'(exp));
            check($sformatf("rand%0d pass", r), 32'(p), 32'(exp == 16'h0));
        end

        cur_lut = nand_lut();
        exp     = model_sig(cur_lut);
        run_vec(1'b1, "hold", sig, p);
        check("hold signature", 32'(sig), 32'(exp));

        @(negedge clk) bus.start = 1'b1;
        @(negedge clk) bus.start = 1'b0;
        repeat (7) @(negedge clk);
        check("midrun cut_pi", 32'(bus.cut_pi), 32'(pats[7]));
        #2 rst_n = 1'b0;
        #1 check_zero("midrun reset");
        @(negedge clk) rst_n = 1'b1;
        run_vec(1'b0, "after reset", sig, p);
        check("after reset signature", 32'(sig), 32'(exp));

        $display("== %0d vectors applied, %0d miscompares ==", vec_n, miss_n);
        $finish;
    end

endmodule
